gat_bram_loader: RTL

- Upstream feeder for the GAT top-level wrapper. Accepts a 32-bit word stream from the PS-side DMA and converts it into BRAM write transactions for the four input memories: H data, H node info, weights and subgraph index.
- Each memory is written through a byte-addressed port: address advances by 4 per word, and word index equals address[ADDR_W+1:2].
- Drives the three load_done levels the top level waits on, plus a subgraph done flag.
- Sits between the AXI-stream/DMA fabric and the wrapper's BRAM write ports.

---
 rtl/gat_pkg.sv | 34 +++
 rtl/gat_bram_wr_strobe.sv | 56 +++++
 rtl/gat_bram_loader.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/gat_pkg.sv
// Shared definitions for the GAT BRAM loader: target encoding, header layout, FSM states.
package gat_pkg;

  localparam logic [1:0] TGT_H_DATA    = 2'd0;
  localparam logic [1:0] TGT_NODE_INFO = 2'd1;
  localparam logic [1:0] TGT_WGT       = 2'd2;
  localparam logic [1:0] TGT_SUBGRAPH  = 2'd3;

  localparam int HDR_TGT_MSB = 31;
  localparam int HDR_TGT_LSB = 30;
  localparam int HDR_N_MSB   = 29;
  localparam int HDR_N_LSB   = 0;
  localparam int HDR_N_W     = 30;

  typedef enum logic [1:0] {
    HDR   = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Bit order of the one-hot matches the done/strobe ordering: h_data, node_info, wgt, subgraph.
  function automatic logic [3:0] tgt_onehot(input logic [1:0] tgt);
    logic [3:0] oh;
    case (tgt)
      TGT_H_DATA:    oh = 4'b0001;
      TGT_NODE_INFO: oh = 4'b0010;
      TGT_WGT:       oh = 4'b0100;
      TGT_SUBGRAPH:  oh = 4'b1000;
      default:       oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/gat_bram_wr_strobe.sv
// Registers shared BRAM write data/address and decodes the target into per-memory ena/wea.
module gat_bram_wr_strobe
  import gat_pkg::*;
#(
  parameter int ADDR_W    = 18,
  parameter int TOP_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [1:0]           wr_tgt,
  input  logic [ADDR_W+1:0]    wr_addr,
  input  logic [TOP_WIDTH-1:0] wr_data,
  output logic [TOP_WIDTH-1:0] bram_din,
  output logic [ADDR_W+1:0]    bram_addra,
  output logic                 h_data_bram_ena,
  output logic                 h_data_bram_wea,
  output logic                 h_node_info_bram_ena,
  output logic                 h_node_info_bram_wea,
  output logic                 wgt_bram_ena,
  output logic                 wgt_bram_wea,
  output logic                 subgraph_bram_ena,
  output logic                 subgraph_bram_wea
);

  logic [TOP_WIDTH-1:0] din_r;
  logic [ADDR_W+1:0]    addr_r;
  logic [3:0]           sel_r;

  // Capture one write per cycle; strobes last exactly one cycle, data/address hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_r  <= {TOP_WIDTH{1'b0}};
      addr_r <= {(ADDR_W+2){1'b0}};
      sel_r  <= 4'b0000;
    end else if (wr_en) begin
      din_r  <= wr_data;
      addr_r <= wr_addr;
      sel_r  <= tgt_onehot(wr_tgt);
    end else begin
      sel_r  <= 4'b0000;
    end
  end

  assign bram_din             = din_r;
  assign bram_addra           = addr_r;
  assign h_data_bram_ena      = sel_r[0];
  assign h_data_bram_wea      = sel_r[0];
  assign h_node_info_bram_ena = sel_r[1];
  assign h_node_info_bram_wea = sel_r[1];
  assign wgt_bram_ena         = sel_r[2];
  assign wgt_bram_wea         = sel_r[2];
  assign subgraph_bram_ena    = sel_r[3];
  assign subgraph_bram_wea    = sel_r[3];

endmodule

// File: rtl/gat_bram_loader.sv
// Converts a header+payload 32-bit word stream into BRAM writes for the four GAT input memories.
module gat_bram_loader
  import gat_pkg::*;
#(
  parameter int H_DATA_DEPTH    = 242101,
  parameter int NODE_INFO_DEPTH = 13264,
  parameter int WEIGHT_DEPTH    = 22928,
  parameter int SUBGRAPH_DEPTH  = 13264,
  parameter int ADDR_W          = 18,
  parameter int TOP_WIDTH       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [TOP_WIDTH-1:0] s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  input  logic                 load_clr,
  output logic [TOP_WIDTH-1:0] bram_din,
  output logic [ADDR_W+1:0]    bram_addra,
  output logic                 h_data_bram_ena,
  output logic                 h_data_bram_wea,
  output logic                 h_node_info_bram_ena,
  output logic                 h_node_info_bram_wea,
  output logic                 wgt_bram_ena,
  output logic                 wgt_bram_wea,
  output logic                 subgraph_bram_ena,
  output logic                 subgraph_bram_wea,
  output logic                 h_data_bram_load_done,
  output logic                 h_node_info_bram_load_done,
  output logic                 wgt_bram_load_done,
  output logic                 subgraph_load_done,
  output logic                 err
);

  state_e               state_r, state_nxt_s;
  logic [ADDR_W:0]      cnt_r, cnt_nxt_s, cnt_inc_s;
  logic [1:0]           tgt_r, tgt_nxt_s, hdr_tgt_s;
  logic [HDR_N_W-1:0]   n_r, n_nxt_s, hdr_n_s, depth_s;
  logic                 s_ready_r, accept_s, wr_en_s, err_set_s, err_r;
  logic [3:0]           done_set_s, done_r;

  assign accept_s  = s_valid & s_ready_r;
  assign hdr_tgt_s = s_data[HDR_TGT_MSB:HDR_TGT_LSB];
  assign hdr_n_s   = s_data[HDR_N_MSB:HDR_N_LSB];
  assign cnt_inc_s = cnt_r + {{ADDR_W{1'b0}}, 1'b1};

  // Depth of the target named by the incoming header, kept at full header width.
  always_comb begin
    depth_s = 30'd0;
    case (hdr_tgt_s)
      TGT_H_DATA:    depth_s = HDR_N_W'(H_DATA_DEPTH);
      TGT_NODE_INFO: depth_s = HDR_N_W'(NODE_INFO_DEPTH);
      TGT_WGT:       depth_s = HDR_N_W'(WEIGHT_DEPTH);
      TGT_SUBGRAPH:  depth_s = HDR_N_W'(SUBGRAPH_DEPTH);
      default:       depth_s = 30'd0;
    endcase
  end

  // Next-state, counter and event decode; DRAIN reuses n_r as a remaining-word countdown.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    tgt_nxt_s   = tgt_r;
    n_nxt_s     = n_r;
    done_set_s  = 4'b0000;
    err_set_s   = 1'b0;
    wr_en_s     = 1'b0;
    case (state_r)
      HDR: begin
        if (accept_s) begin
          if (hdr_n_s == 30'd0) begin
            done_set_s = tgt_onehot(hdr_tgt_s);
          end else if (hdr_n_s <= depth_s) begin
            state_nxt_s = LOAD;
            tgt_nxt_s   = hdr_tgt_s;
            n_nxt_s     = hdr_n_s;
            cnt_nxt_s   = {(ADDR_W+1){1'b0}};
          end else begin
            state_nxt_s = DRAIN;
            n_nxt_s     = hdr_n_s;
            err_set_s   = 1'b1;
          end
        end else begin
          state_nxt_s = HDR;
        end
      end
      LOAD: begin
        if (accept_s) begin
          wr_en_s   = 1'b1;
          cnt_nxt_s = cnt_inc_s;
          if (HDR_N_W'(cnt_inc_s) == n_r) begin
            done_set_s  = tgt_onehot(tgt_r);
            state_nxt_s = HDR;
          end else if (s_last) begin
            err_set_s   = 1'b1;
            state_nxt_s = HDR;
          end else begin
            state_nxt_s = LOAD;
          end
        end else begin
          state_nxt_s = LOAD;
        end
      end
      DRAIN: begin
        if (accept_s) begin
          n_nxt_s = n_r - 30'd1;
          if ((n_r == 30'd1) || s_last) begin
            state_nxt_s = HDR;
          end else begin
            state_nxt_s = DRAIN;
          end
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: state_nxt_s = HDR;
    endcase
  end

  // Control state; a set event in the same cycle as load_clr keeps the flag high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= HDR;
      cnt_r     <= {(ADDR_W+1){1'b0}};
      tgt_r     <= 2'd0;
      n_r       <= 30'd0;
      s_ready_r <= 1'b0;
      done_r    <= 4'b0000;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      tgt_r     <= tgt_nxt_s;
      n_r       <= n_nxt_s;
      s_ready_r <= 1'b1;
      done_r    <= (done_r & ~{4{load_clr}}) | done_set_s;
      err_r     <= (err_r & ~load_clr) | err_set_s;
    end
  end

  assign s_ready                    = s_ready_r;
  assign err                        = err_r;
  assign h_data_bram_load_done      = done_r[0];
  assign h_node_info_bram_load_done = done_r[1];
  assign wgt_bram_load_done         = done_r[2];
  assign subgraph_load_done         = done_r[3];

  gat_bram_wr_strobe #(
    .ADDR_W    (ADDR_W),
    .TOP_WIDTH (TOP_WIDTH)
  ) u_wr_strobe (
    .clk                  (clk),
    .rst_n                (rst_n),
    .wr_en                (wr_en_s),
    .wr_tgt               (tgt_r),
    .wr_addr              ({cnt_r[ADDR_W-1:0], 2'b00}),
    .wr_data              (s_data),
    .bram_din             (bram_din),
    .bram_addra           (bram_addra),
    .h_data_bram_ena      (h_data_bram_ena),
    .h_data_bram_wea      (h_data_bram_wea),
    .h_node_info_bram_ena (h_node_info_bram_ena),
    .h_node_info_bram_wea (h_node_info_bram_wea),
    .wgt_bram_ena         (wgt_bram_ena),
    .wgt_bram_wea         (wgt_bram_wea),
    .subgraph_bram_ena    (subgraph_bram_ena),
    .subgraph_bram_wea    (subgraph_bram_wea)
  );

endmodule
